// File: rtl/cabac_pkg.sv
// Shared CABAC definitions: bin entry layout and
// inter_pred_idc context base indices.
package cabac_pkg;

  localparam int CTX_W_DEFAULT = 6;

  typedef struct packed {
    logic                     bin;
    logic [CTX_W_DEFAULT-1:0] ctx;
    logic                     bypass;
    logic                     last;
  } bin_entry_t;

  localparam logic [CTX_W_DEFAULT-1:0] IPI_CTX_BASE  = 6'd0;
  localparam logic [CTX_W_DEFAULT-1:0] IPI_CTX_L0L1  = 6'd4;
  localparam logic [CTX_W_DEFAULT-1:0] IPI_CTX_BI    = 6'd5;

endpackage

// File: rtl/bin_fifo_mem.sv
// Bin FIFO storage: one synchronous write port and
// one asynchronous read port for fall-through output.
module bin_fifo_mem #(
  parameter int W     = 9,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [DEPTH];

  // write the pushed entry into its slot
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/bin_buffer.sv
// Elastic bin FIFO between binarizers and CABAC engine.
// Optional statistics counters: BIN_BUFFER_STATS_EN.
module bin_buffer
  import cabac_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int CTX_W     = CTX_W_DEFAULT,
  parameter int AF_MARGIN = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_bin_valid,
  input  logic                     in_bin_value,
  input  logic [CTX_W-1:0]         in_ctx_idx,
  input  logic                     in_bypass,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_bin,
  output logic [CTX_W-1:0]         out_ctx_idx,
  output logic                     out_bypass,
  output logic                     out_last,
  output logic                     elem_avail,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic                     almost_full,
  output logic                     overflow
`ifdef BIN_BUFFER_STATS_EN
  ,
  output logic [31:0]              stat_bins,
  output logic [15:0]              stat_elems
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE   = (AW+1)'(1);
  localparam logic [AW:0] AF_TH = (AW+1)'(DEPTH - AF_MARGIN);

  typedef struct packed {
    logic             bin;
    logic [CTX_W-1:0] ctx;
    logic             bypass;
    logic             last;
  } entry_t;

  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic [AW:0] r_fill;
  logic [AW:0] r_elem_cnt;
  logic        r_af;
  logic        r_ovf;

  logic        w_clr;
  logic        w_full;
  logic        w_empty;
  logic        w_pop;
  logic        w_push;
  logic        w_drop;
  logic        w_we;
  logic [AW:0] w_fill_nxt;
  logic [AW:0] w_elem_nxt;
  entry_t      w_wr_entry;
  entry_t      w_rd_entry;

  assign w_clr   = rst | flush;
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = ~w_empty & out_ready;
  assign w_push  = in_bin_valid & (~w_full | w_pop);
  assign w_drop  = in_bin_valid & w_full & ~w_pop;
  assign w_we    = w_push & ~w_clr;

  assign w_wr_entry = '{bin:    in_bin_value,
                        ctx:    in_ctx_idx,
                        bypass: in_bypass,
                        last:   in_last};

  bin_fifo_mem #(
    .W     ($bits(entry_t)),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr[AW-1:0]),
    .i_wdata (w_wr_entry),
    .i_raddr (r_rd_ptr[AW-1:0]),
    .o_rdata (w_rd_entry)
  );

  // next fill level and complete-element count
  always_comb begin
    w_fill_nxt = r_fill;
    w_elem_nxt = r_elem_cnt;
    if (w_push && !w_pop)      w_fill_nxt = r_fill + ONE;
    else if (w_pop && !w_push) w_fill_nxt = r_fill - ONE;
    if ((w_push && in_last) && !(w_pop && w_rd_entry.last))
      w_elem_nxt = r_elem_cnt + ONE;
    else if (!(w_push && in_last) && (w_pop && w_rd_entry.last))
      w_elem_nxt = r_elem_cnt - ONE;
  end

  // pointers, counters and flags; clear wins over push/pop
  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fill     <= '0;
      r_elem_cnt <= '0;
      r_af       <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + ONE;
      r_fill     <= w_fill_nxt;
      r_elem_cnt <= w_elem_nxt;
      r_af       <= (w_fill_nxt >= AF_TH);
      if (w_drop) r_ovf <= 1'b1;
    end
  end

  assign out_valid   = ~w_empty;
  assign out_bin     = ~w_empty & w_rd_entry.bin;
  assign out_ctx_idx = w_empty ? '0 : w_rd_entry.ctx;
  assign out_bypass  = ~w_empty & w_rd_entry.bypass;
  assign out_last    = ~w_empty & w_rd_entry.last;
  assign elem_avail  = (r_elem_cnt != '0);
  assign fill_level  = r_fill;
  assign almost_full = r_af;
  assign overflow    = r_ovf;

`ifdef BIN_BUFFER_STATS_EN
  logic [31:0] r_stat_bins;
  logic [15:0] r_stat_elems;

  // lifetime totals; survive flush, cleared by rst only
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_bins  <= '0;
      r_stat_elems <= '0;
    end else if (w_we) begin
      r_stat_bins <= r_stat_bins + 32'd1;
      if (in_last) r_stat_elems <= r_stat_elems + 16'd1;
    end
  end

  assign stat_bins  = r_stat_bins;
  assign stat_elems = r_stat_elems;
`endif

endmodule
